// File: rtl/shift_pipe_pkg.sv
// -----------------------------------------------------------------------------
// shift_pipe_pkg
// Shared definitions for the shift_pipe delay line.
//   MODE_HOLD   : every stage keeps its contents
//   MODE_SHIFT  : stage 0 takes the serial input, stage i takes stage i-1
//   MODE_LOAD   : every stage takes its slice of the parallel load word
//   MODE_ROTATE : like SHIFT, but stage 0 takes the last stage (circular)
// -----------------------------------------------------------------------------
package shift_pipe_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'd0;
    localparam logic [1:0] MODE_SHIFT  = 2'd1;
    localparam logic [1:0] MODE_LOAD   = 2'd2;
    localparam logic [1:0] MODE_ROTATE = 2'd3;

endpackage : shift_pipe_pkg

// File: rtl/shift_pipe_stage.sv
// -----------------------------------------------------------------------------
// shift_pipe_stage
// One data + valid register of the shift_pipe delay line with a 4:1
// next-state selection driven by the shared mode.
// Ports:
//   clk_i        : clock, all updates on the rising edge
//   rst_i        : synchronous active-high reset, clears data and valid
//   mode_i       : HOLD / SHIFT / LOAD / ROTATE
//   shift_data_i : data source used in SHIFT (serial input or previous stage)
//   shift_vld_i  : valid source used in SHIFT
//   load_data_i  : this stage's slice of the parallel load word
//   wrap_data_i  : data source used in ROTATE (last stage or previous stage)
//   wrap_vld_i   : valid source used in ROTATE
//   data_o       : registered stage data
//   vld_o        : registered stage valid
// -----------------------------------------------------------------------------
module shift_pipe_stage
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] shift_data_i,
    input  logic             shift_vld_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic [WIDTH-1:0] wrap_data_i,
    input  logic             wrap_vld_i,
    output logic [WIDTH-1:0] data_o,
    output logic             vld_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        case (mode_i)
            MODE_SHIFT: begin
                data_d = shift_data_i;
                vld_d  = shift_vld_i;
            end
            MODE_LOAD: begin
                data_d = load_data_i;
                vld_d  = 1'b1;
            end
            MODE_ROTATE: begin
                data_d = wrap_data_i;
                vld_d  = wrap_vld_i;
            end
            default: begin
                data_d = data_q;
                vld_d  = vld_q;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;

endmodule : shift_pipe_stage

// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
// DEPTH-stage, WIDTH-bit shift register with per-stage valid bits and four
// runtime modes (hold, shift, parallel load, rotate). Usable as a delay line,
// serial-to-parallel converter or circular buffer.
// Ports:
//   clk_i       : clock
//   rst_i       : synchronous active-high reset, dominates mode_i
//   mode_i      : 0=HOLD 1=SHIFT 2=LOAD 3=ROTATE, takes effect at next edge
//   d_i         : serial input into stage 0 (SHIFT)
//   d_valid_i   : valid tag for d_i
//   load_data_i : parallel load word, stage i at [i*WIDTH +: WIDTH]
//   tap_sel_i   : stage index shown on tap_q_o
//   q_o         : last stage data
//   q_valid_o   : last stage valid
//   tap_q_o     : data of stage tap_sel_i, zero if tap_sel_i >= DEPTH
//   par_q_o     : all stages, stage i at [i*WIDTH +: WIDTH]
//   count_o     : number of stages holding valid data
// -----------------------------------------------------------------------------
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int TAP_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             mode_i,
    input  logic [WIDTH-1:0]       d_i,
    input  logic                   d_valid_i,
    input  logic [DEPTH*WIDTH-1:0] load_data_i,
    input  logic [TAP_W-1:0]       tap_sel_i,
    output logic [WIDTH-1:0]       q_o,
    output logic                   q_valid_o,
    output logic [WIDTH-1:0]       tap_q_o,
    output logic [DEPTH*WIDTH-1:0] par_q_o,
    output logic [CNT_W-1:0]       count_o
);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_vld;

    logic [WIDTH-1:0] shift_data [DEPTH];
    logic [DEPTH-1:0] shift_vld;
    logic [WIDTH-1:0] wrap_data  [DEPTH];
    logic [DEPTH-1:0] wrap_vld;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        // Stage 0 is the only one whose SHIFT and ROTATE sources differ:
        // the serial input versus the wrapped-around last stage.
        if (i == 0) begin : g_head
            assign shift_data[i] = d_i;
            assign shift_vld[i]  = d_valid_i;
            assign wrap_data[i]  = stage_data[DEPTH-1];
            assign wrap_vld[i]   = stage_vld[DEPTH-1];
        end else begin : g_body
            assign shift_data[i] = stage_data[i-1];
            assign shift_vld[i]  = stage_vld[i-1];
            assign wrap_data[i]  = stage_data[i-1];
            assign wrap_vld[i]   = stage_vld[i-1];
        end

        shift_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .mode_i       (mode_i),
            .shift_data_i (shift_data[i]),
            .shift_vld_i  (shift_vld[i]),
            .load_data_i  (load_data_i[i*WIDTH +: WIDTH]),
            .wrap_data_i  (wrap_data[i]),
            .wrap_vld_i   (wrap_vld[i]),
            .data_o       (stage_data[i]),
            .vld_o        (stage_vld[i])
        );

        assign par_q_o[i*WIDTH +: WIDTH] = stage_data[i];
    end

    assign q_o       = stage_data[DEPTH-1];
    assign q_valid_o = stage_vld[DEPTH-1];

    // Tap mux: indices beyond the last stage (non-power-of-two DEPTH) read zero.
    always_comb begin
        tap_q_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel_i == TAP_W'(i)) begin
                tap_q_o = stage_data[i];
            end
        end
    end

    always_comb begin
        count_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_o = count_o + CNT_W'(stage_vld[i]);
        end
    end

endmodule : shift_pipe
